// File: rtl/preg_free_list.sv
// Physical-register free list for the rename stage.
// A circular FIFO of free physical tags. After reset it loads tags
// FIRST_FREE .. FIRST_FREE+DEPTH-1 by itself, one per cycle, then serves one
// allocation and one release per cycle. A release into a full list is dropped
// and latches a sticky overflow flag.
module preg_free_list #(
    parameter int PREG_W     = 6,
    parameter int DEPTH      = 32,
    parameter int FIRST_FREE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req,
    output logic              alloc_grant,
    output logic [PREG_W-1:0] alloc_preg,
    input  logic              rel_valid,
    input  logic [PREG_W-1:0] rel_preg,
    output logic              ready,
    output logic              empty,
    output logic [PREG_W-1:0] count,
    output logic              overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PREG_W:0] DEPTH_C = (PREG_W+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q;
    logic [AW-1:0]     head_q;
    logic [AW-1:0]     head_d;
    logic [AW-1:0]     tail_q;
    logic [AW-1:0]     tail_d;
    logic [AW-1:0]     idx_q;
    logic [PREG_W-1:0] count_q;
    logic [PREG_W-1:0] count_d;
    logic              empty_q;
    logic              ready_q;
    logic              overflow_q;
    logic [PREG_W-1:0] mem_q [DEPTH];

    logic              run_s;
    logic              grant_s;
    logic              rel_nz_s;
    logic [PREG_W:0]   net_count_s;
    logic              full_s;
    logic              rel_acc_s;
    logic              rel_ovf_s;
    logic              wr_en_s;
    logic [PREG_W-1:0] wr_data_s;

    // Grant and release decisions; fullness accounts for a same-cycle grant.
    always_comb begin
        run_s       = (state_q == ST_RUN);
        grant_s     = run_s & alloc_req & ~empty_q;
        rel_nz_s    = run_s & rel_valid & (rel_preg != {PREG_W{1'b0}});
        net_count_s = {1'b0, count_q} - {{PREG_W{1'b0}}, grant_s};
        full_s      = (net_count_s >= DEPTH_C);
        rel_acc_s   = rel_nz_s & ~full_s;
        rel_ovf_s   = rel_nz_s & full_s;
    end

    // Next pointers, occupancy and the single storage write port.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = rel_preg;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (run_s) begin
            wr_en_s   = rel_acc_s;
            wr_data_s = rel_preg;
            if (grant_s) begin
                head_d = head_q + AW'(1);
            end else begin
                head_d = head_q;
            end
            if (rel_acc_s) begin
                tail_d = tail_q + AW'(1);
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + {{(PREG_W-1){1'b0}}, rel_acc_s}
                              - {{(PREG_W-1){1'b0}}, grant_s};
        end else begin
            // Init: load the next sequential tag at the tail.
            wr_en_s   = 1'b1;
            wr_data_s = PREG_W'(FIRST_FREE) + PREG_W'(idx_q);
            head_d    = head_q;
            tail_d    = tail_q + AW'(1);
            count_d   = count_q + PREG_W'(1);
        end
    end

    // Controller FSM plus pointer, count and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            head_q     <= {AW{1'b0}};
            tail_q     <= {AW{1'b0}};
            idx_q      <= {AW{1'b0}};
            count_q    <= {PREG_W{1'b0}};
            empty_q    <= 1'b1;
            ready_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            empty_q <= (count_d == {PREG_W{1'b0}});
            case (state_q)
                ST_INIT: begin
                    idx_q      <= idx_q + AW'(1);
                    overflow_q <= overflow_q;
                    if (idx_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= ST_INIT;
                        ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                    idx_q   <= idx_q;
                    ready_q <= 1'b1;
                    if (rel_ovf_s) begin
                        overflow_q <= 1'b1;
                    end else begin
                        overflow_q <= overflow_q;
                    end
                end
                default: begin
                    state_q    <= ST_INIT;
                    idx_q      <= {AW{1'b0}};
                    ready_q    <= 1'b0;
                    overflow_q <= overflow_q;
                end
            endcase
        end
    end

    // Tag storage; contents need no reset because init rewrites every slot.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            mem_q[tail_q] <= wr_data_s;
        end
    end

    assign alloc_grant = grant_s;
    assign alloc_preg  = mem_q[head_q];
    assign ready       = ready_q;
    assign empty       = empty_q;
    assign count       = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list: queue-based reference model,
// directed sequences, a vector table and randomized traffic.
module tb_preg_free_list;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_req = 1'b0;
    logic       rel_valid = 1'b0;
    logic [5:0] rel_preg = 6'd0;
    logic       alloc_grant;
    logic [5:0] alloc_preg;
    logic       ready;
    logic       empty;
    logic [5:0] count;
    logic       overflow;

    preg_free_list #(.PREG_W(6), .DEPTH(32), .FIRST_FREE(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req   (alloc_req),
        .alloc_grant (alloc_grant),
        .alloc_preg  (alloc_preg),
        .rel_valid   (rel_valid),
        .rel_preg    (rel_preg),
        .ready       (ready),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: free tags in grant order.
    int   m_q[$];
    bit   m_ready;
    bit   m_ovf;
    int   m_init;
    logic       g_grant;
    logic [5:0] g_preg;

    typedef struct {
        bit         req;
        bit         rv;
        logic [5:0] rp;
        bit         eg;
        logic [5:0] ep;
        int         ec;
        bit         eo;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready = 1'b0;
        m_ovf   = 1'b0;
        m_init  = 0;
    endtask

    // One clock cycle: drive, compare against model before the edge, advance model.
    task automatic step(input bit r, input bit rq, input bit rv, input logic [5:0] rp);
        bit eg;
        int sz;
        rst = r; alloc_req = rq; rel_valid = rv; rel_preg = rp;
        #3;
        sz = m_q.size();
        eg = m_ready && rq && (sz > 0);
        g_grant = alloc_grant;
        g_preg  = alloc_preg;
        chk("grant", 32'(alloc_grant), 32'(eg));
        if (eg) chk("preg", 32'(alloc_preg), 32'(m_q[0]));
        chk("ready", 32'(ready), 32'(m_ready));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("count", 32'(count), 32'(sz));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else if (!m_ready) begin
            m_q.push_back(32 + m_init);
            m_init++;
            if (m_init == 32) m_ready = 1'b1;
        end else begin
            if (eg) void'(m_q.pop_front());
            if (rv && rp != 6'd0) begin
                if (sz - int'(eg) >= 32) m_ovf = 1'b1;
                else m_q.push_back(int'(rp));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        // Reset state
        step(1'b1, 1'b0, 1'b0, 6'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);

        // Init: ready exactly after 32 edges
        for (int i = 0; i < 32; i++) begin
            if (i == 31) chk("ready_before_32", 32'(ready), 32'd0);
            step(1'b0, 1'b1, 1'b1, 6'd9);
        end
        chk("ready_at_32", 32'(ready), 32'd1);
        chk("count_at_32", 32'(count), 32'd32);
        chk("empty_at_32", 32'(empty), 32'd0);

        // Drain: tags 32..63 in order
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 6'd0);
            chk("drain_grant", 32'(g_grant), 32'd1);
            chk("drain_tag", 32'(g_preg), 32'(32 + i));
        end
        chk("drained_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 1'b0, 6'd0);
        chk("empty_no_grant", 32'(g_grant), 32'd0);

        // Release into empty list: no bypass
        step(1'b0, 1'b1, 1'b1, 6'd40);
        chk("no_bypass", 32'(g_grant), 32'd0);
        step(1'b0, 1'b1, 1'b0, 6'd0);
        chk("rel40_grant", 32'(g_grant), 32'd1);
        chk("rel40_tag", 32'(g_preg), 32'd40);
        chk("rel40_count", 32'(count), 32'd0);

        // p0 release ignored
        step(1'b0, 1'b0, 1'b1, 6'd0);
        chk("p0_count", 32'(count), 32'd0);

        // Wrap-around: release and allocate every cycle
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b1, 6'(i + 1));
            chk("wrap_grant", 32'(g_grant), 32'(i > 0));
            if (i > 0) chk("wrap_tag", 32'(g_preg), 32'(i));
            chk("wrap_count", 32'(count), 32'd1);
        end
        step(1'b0, 1'b1, 1'b0, 6'd0);
        chk("wrap_last", 32'(g_preg), 32'd40);

        // Reset in RUN with count 7
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 6'(10 + i));
        chk("count7", 32'(count), 32'd7);
        step(1'b1, 1'b0, 1'b0, 6'd0);
        chk("run_rst_ready", 32'(ready), 32'd0);
        chk("run_rst_count", 32'(count), 32'd0);

        // Reset at INIT cycle 10
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 6'd0);
        chk("init10_count", 32'(count), 32'd10);
        step(1'b1, 1'b1, 1'b1, 6'd3);
        chk("init_rst_count", 32'(count), 32'd0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b0, 6'd0);
        chk("reinit_ready", 32'(ready), 32'd1);

        // Vector table from a full list holding 32..63
        tbl[0] = '{req: 1'b1, rv: 1'b1, rp: 6'd5,  eg: 1'b1, ep: 6'd32, ec: 32, eo: 1'b0};
        tbl[1] = '{req: 1'b0, rv: 1'b1, rp: 6'd0,  eg: 1'b0, ep: 6'd0,  ec: 32, eo: 1'b0};
        tbl[2] = '{req: 1'b0, rv: 1'b1, rp: 6'd7,  eg: 1'b0, ep: 6'd0,  ec: 32, eo: 1'b1};
        tbl[3] = '{req: 1'b1, rv: 1'b0, rp: 6'd0,  eg: 1'b1, ep: 6'd33, ec: 31, eo: 1'b1};
        tbl[4] = '{req: 1'b1, rv: 1'b1, rp: 6'd0,  eg: 1'b1, ep: 6'd34, ec: 30, eo: 1'b1};
        tbl[5] = '{req: 1'b0, rv: 1'b1, rp: 6'd9,  eg: 1'b0, ep: 6'd0,  ec: 31, eo: 1'b1};
        tbl[6] = '{req: 1'b1, rv: 1'b1, rp: 6'd50, eg: 1'b1, ep: 6'd35, ec: 31, eo: 1'b1};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, tbl[i].req, tbl[i].rv, tbl[i].rp);
            chk("tbl_grant", 32'(g_grant), 32'(tbl[i].eg));
            if (tbl[i].eg) chk("tbl_tag", 32'(g_preg), 32'(tbl[i].ep));
            chk("tbl_count", 32'(count), 32'(tbl[i].ec));
            chk("tbl_overflow", 32'(overflow), 32'(tbl[i].eo));
        end

        // Reset clears overflow
        step(1'b1, 1'b0, 1'b0, 6'd0);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Randomized traffic against the model, alternating bias phases
        for (int i = 0; i < 2000; i++) begin
            bit r;
            bit rq;
            bit rv;
            int p;
            p  = ((i / 150) % 2 == 1) ? 80 : 30;
            r  = ($urandom_range(299, 0) == 0);
            rq = ($urandom_range(99, 0) < p);
            rv = ($urandom_range(99, 0) < (110 - p));
            step(r, rq, rv, 6'($urandom_range(63, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
